sound_latch_bridge: RTL

- Responder for the 68K→Z80 sound-command path, driven by the sound-latch, latch-read and latch-clear selects from the address decoder.
- Captures a command byte from the 68K and generates 68K DTACK.
- Presents the byte to the sound Z80 and handles Z80 read and clear accesses.
- Generates the sound Z80's periodic maskable interrupt, including IM-acknowledge clearing.

---
 rtl/sound_pkg.sv | 17 +
 rtl/z80_irq_timer.sv | 58 +++++
 rtl/sound_latch_bridge.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared types and constants for the 68K-to-Z80 sound command bridge.
// Contents: DTACK FSM state enum, default timing parameters, latch clear value.
// Imported by sound_latch_bridge and z80_irq_timer.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } dtack_state_e;

    localparam int unsigned DTACK_WAIT_DEF = 2;
    localparam int unsigned IRQ_DIV_DEF    = 512;

    localparam logic [7:0] LATCH_CLR_VAL = 8'h00;

endpackage

// File: rtl/z80_irq_timer.sv
// Periodic maskable interrupt for the sound Z80.
// Ports: clk_sys/reset, clk_en_z80 (counter advance), z80_m1_n/z80_iorq_n
// (interrupt acknowledge), z80_int_n (registered, active low).
module z80_irq_timer
    import sound_pkg::*;
#(
    parameter int unsigned IRQ_DIV = IRQ_DIV_DEF
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clk_en_z80,
    input  logic z80_m1_n,
    input  logic z80_iorq_n,
    output logic z80_int_n
);

    localparam int unsigned CNT_W = $clog2(IRQ_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IRQ_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             int_n_q, int_n_d;
    logic             tick;
    logic             ack;

    assign tick = clk_en_z80 && (cnt_q == CNT_LAST);
    assign ack  = !z80_m1_n && !z80_iorq_n;

    always_comb begin
        cnt_d = cnt_q;
        if (clk_en_z80) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // A tick landing on the same cycle as an acknowledge re-raises the
    // request, so the new interrupt is not lost.
    always_comb begin
        int_n_d = int_n_q;
        if (tick) begin
            int_n_d = 1'b0;
        end else if (ack) begin
            int_n_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q   <= '0;
            int_n_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            int_n_q <= int_n_d;
        end
    end

    assign z80_int_n = int_n_q;

endmodule

// File: rtl/sound_latch_bridge.sv
// 68K-to-Z80 sound command latch with DTACK generation and Z80 interrupt timer.
// Ports: 68K side (latch_cs, rw, lds_n, din, dtack_n); Z80 side (clk_en_z80,
// read/clear selects, rd/wr/m1/iorq strobes, dout, int_n); latch_pending status.
module sound_latch_bridge
    import sound_pkg::*;
#(
    parameter int unsigned DTACK_WAIT = DTACK_WAIT_DEF,
    parameter int unsigned IRQ_DIV    = IRQ_DIV_DEF
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       m68k_latch_cs,
    input  logic       m68k_rw,
    input  logic       m68k_lds_n,
    input  logic [7:0] m68k_din,
    output logic       m68k_dtack_n,
    input  logic       clk_en_z80,
    input  logic       z80_latch_r_cs,
    input  logic       z80_latch_clr_cs,
    input  logic       z80_rd_n,
    input  logic       z80_wr_n,
    input  logic       z80_m1_n,
    input  logic       z80_iorq_n,
    output logic [7:0] z80_dout,
    output logic       latch_pending,
    output logic       z80_int_n
);

    // ---------------- strobe qualification and edge detection ----------------
    logic qual68, wr68, z_rd_strb, z_clr_strb;
    logic qual68_q, wr68_q, z_rd_q, z_clr_q;
    logic qual68_rise, commit, rd_ev, clr_ev;

    assign qual68     = m68k_latch_cs && !m68k_lds_n;
    assign wr68       = qual68 && !m68k_rw;
    assign z_rd_strb  = z80_latch_r_cs && (!z80_rd_n || !z80_wr_n);
    assign z_clr_strb = z80_latch_clr_cs && (!z80_rd_n || !z80_wr_n);

    assign qual68_rise = qual68 && !qual68_q;
    assign commit      = wr68 && !wr68_q;
    assign rd_ev       = z_rd_strb && !z_rd_q;
    assign clr_ev      = z_clr_strb && !z_clr_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            qual68_q <= 1'b0;
            wr68_q   <= 1'b0;
            z_rd_q   <= 1'b0;
            z_clr_q  <= 1'b0;
        end else begin
            qual68_q <= qual68;
            wr68_q   <= wr68;
            z_rd_q   <= z_rd_strb;
            z_clr_q  <= z_clr_strb;
        end
    end

    // ---------------- command latch ----------------
    logic [7:0] latch_q, latch_d;
    logic       pend_q, pend_d;

    // 68K commit beats any Z80 event; a clear beats a plain read.
    always_comb begin
        latch_d = latch_q;
        pend_d  = pend_q;
        if (commit) begin
            latch_d = m68k_din;
            pend_d  = 1'b1;
        end else if (clr_ev) begin
            latch_d = LATCH_CLR_VAL;
            pend_d  = 1'b0;
        end else if (rd_ev) begin
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            latch_q <= LATCH_CLR_VAL;
            pend_q  <= 1'b0;
        end else begin
            latch_q <= latch_d;
            pend_q  <= pend_d;
        end
    end

    // Z80 sees the registered latch, i.e. the value before a same-cycle commit.
    assign z80_dout      = latch_q;
    assign latch_pending = pend_q;

    // ---------------- DTACK FSM ----------------
    dtack_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         dtack_n_q, dtack_n_d;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dtack_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dtack_n_q <= dtack_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (qual68_rise) begin
                    state_d = WAIT;
                    cnt_d   = 4'(DTACK_WAIT);
                end
            end
            WAIT: begin
                if (!qual68) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                if (!qual68) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // DTACK is registered from the next state so it is glitch-free and
    // appears on the first cycle spent in ACK.
    always_comb begin
        dtack_n_d = (state_d != ACK);
    end

    assign m68k_dtack_n = dtack_n_q;

    // ---------------- Z80 interrupt timer ----------------
    z80_irq_timer #(
        .IRQ_DIV (IRQ_DIV)
    ) u_irq (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .clk_en_z80 (clk_en_z80),
        .z80_m1_n   (z80_m1_n),
        .z80_iorq_n (z80_iorq_n),
        .z80_int_n  (z80_int_n)
    );

endmodule
